crc_16_ccitt_checker: RTL and testbench
=======================================

CRC_16_CCITT_CHECKER -- requirements
Module: CRC_16_CCITT_Checker

Interface
REQ-001 Parameter MAX_BYTES, default 1024, maximum accepted frame length in bytes including the 2 CRC bytes; legal range 3..65535.
REQ-002 i_Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_DV  input  1  byte valid; i_Data is consumed on any rising edge where i_DV=1.
REQ-005 i_Data  input  8  frame byte: payload bytes first, then CRC MSB, then CRC LSB.
REQ-006 i_EOF  input  1  qualified by i_DV; marks the last byte of the frame (CRC LSB).
REQ-007 i_Abort  input  1  synchronous frame abort; has priority over i_DV.
REQ-008 o_Busy  output  1  high while a frame is open (state ACCUM or DISCARD).
REQ-009 o_Done  output  1  one-cycle pulse reporting frame result.
REQ-010 o_CRC_OK  output  1  valid with o_Done; 1 = residue zero and length legal.
REQ-011 o_Len_Err  output  1  valid with o_Done; 1 = length <3 or >MAX_BYTES.
REQ-012 o_Byte_Count  output  16  bytes consumed in the reported frame, held until the next o_Done.
REQ-013 o_Residue  output  16  final CRC register value of the reported frame, held until the next o_Done.

Function
REQ-014 Polynomial x^16+x^12+x^5+1 (0x1021), init 0xFFFF, MSB-first, no reflection, no final XOR; 8 bits are processed per accepted byte in one cycle.
REQ-015 States: IDLE, ACCUM, DISCARD.
REQ-016 IDLE, i_DV=1: CRC := update(0xFFFF, i_Data), count := 1; go to ACCUM, or report immediately if i_EOF=1.
REQ-017 ACCUM, i_DV=1: CRC := update(CRC, i_Data), count++; if count would exceed MAX_BYTES and i_EOF=0, go to DISCARD.
REQ-018 DISCARD: bytes are counted (saturating at 0xFFFF) but the CRC is frozen; i_EOF reports and returns to IDLE.
REQ-019 On an accepted i_EOF byte, o_Done pulses high exactly 1 cycle later with o_Byte_Count, o_Residue, o_Len_Err and o_CRC_OK registered.
REQ-020 The FSM returns to IDLE in the same edge that accepts the EOF byte, so the next frame's first byte is accepted on the very next cycle (back-to-back frames, no gap).
REQ-021 o_CRC_OK = (residue==0x0000) AND NOT o_Len_Err; a frame with a length error always reports o_CRC_OK=0.
REQ-022 Cycles with i_DV=0 inside a frame leave CRC, count and state unchanged (gaps of any length are allowed).
REQ-023 i_Abort=1 returns the FSM to IDLE on that edge and discards the open frame: no o_Done, and held outputs are unchanged.
REQ-024 i_Abort in IDLE has no effect.
REQ-025 i_EOF with i_DV=0 is ignored.

Reset
REQ-026 Asserting i_Rst_n=0 forces IDLE immediately, regardless of the clock.
REQ-027 Reset values: o_Busy=0, o_Done=0, o_CRC_OK=0, o_Len_Err=0, o_Byte_Count=0, o_Residue=0xFFFF, CRC register=0xFFFF.
REQ-028 Reset asserted mid-frame discards that frame without an o_Done pulse.

Configuration
REQ-029 Macro CRC_CHECKER_STATS_EN, when defined, adds outputs o_Good_Count[15:0] and o_Bad_Count[15:0].
REQ-030 With the macro defined, each o_Done increments o_Good_Count (o_CRC_OK=1) or o_Bad_Count (o_CRC_OK=0); both counters saturate at 0xFFFF and reset to 0.
REQ-031 Without the macro, neither the outputs nor the counter logic exist, and all other behaviour is identical.

Verification
REQ-032 Bytes 0x31..0x39 then 0x29,0xB1 with EOF on the last byte, i_DV held continuously -> o_Done one cycle later; o_CRC_OK=1, o_Residue=0x0000, o_Byte_Count=11.
REQ-033 Same frame with the 0x35 byte changed to 0x36 -> o_CRC_OK=0, o_Residue!=0, o_Len_Err=0.
REQ-034 Same valid frame with 10 idle cycles between bytes 8 and 9 -> o_CRC_OK=1; then a second valid frame starting the cycle after EOF -> two o_Done pulses, both OK.
REQ-035 2-byte frame 0x1D,0x0F with EOF -> o_Len_Err=1, o_CRC_OK=0, o_Byte_Count=2; with MAX_BYTES=8, the 11-byte valid frame -> o_Len_Err=1, o_Byte_Count=11.
REQ-036 i_Abort after 5 bytes, then the valid frame -> exactly one o_Done with o_CRC_OK=1, o_Byte_Count=11.
REQ-037 i_Rst_n pulsed low mid-frame -> all outputs at their reset values, no o_Done pulse; with CRC_CHECKER_STATS_EN defined, REQ-032 followed by REQ-033 -> o_Good_Count=1, o_Bad_Count=1.

Source files
------------

// File: rtl/crc_16_ccitt_checker.sv
// CRC-16/CCITT (0x1021, init 0xFFFF, MSB-first) frame checker with length policing.
// Optional macro CRC_CHECKER_STATS_EN adds saturating good/bad frame counters.
module crc_16_ccitt_checker #(
    parameter int unsigned MAX_BYTES = 1024
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_DV,
    input  logic [7:0]  i_Data,
    input  logic        i_EOF,
    input  logic        i_Abort,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_CRC_OK,
    output logic        o_Len_Err,
    output logic [15:0] o_Byte_Count,
    output logic [15:0] o_Residue
`ifdef CRC_CHECKER_STATS_EN
    ,
    output logic [15:0] o_Good_Count,
    output logic [15:0] o_Bad_Count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [16:0] MAX_BYTES_C = 17'(MAX_BYTES);

    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] count_q, count_d;
    logic        busy_q, done_q, crc_ok_q, len_err_q;
    logic [15:0] byte_count_q, residue_q;

    logic [15:0] crc_base_s, crc_upd_s;
    logic [16:0] count_inc_s;
    logic [15:0] count_sat_s;
    logic        too_long_s;
    logic        report_s, len_err_s, crc_ok_s;
    logic [15:0] rpt_count_s, rpt_crc_s;

    // A byte seen in IDLE always starts a fresh CRC from the init value.
    assign crc_base_s  = (state_q == ST_IDLE) ? 16'hFFFF : crc_q;
    assign crc_upd_s   = crc16_upd(crc_base_s, i_Data);
    assign count_inc_s = {1'b0, count_q} + 17'd1;
    assign count_sat_s = count_inc_s[16] ? 16'hFFFF : count_inc_s[15:0];
    assign too_long_s  = (count_inc_s > MAX_BYTES_C);
    assign crc_ok_s    = (rpt_crc_s == 16'h0000) && !len_err_s;

    // Next-state, CRC/count update and end-of-frame report decode.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        count_d     = count_q;
        report_s    = 1'b0;
        len_err_s   = 1'b0;
        rpt_count_s = count_q;
        rpt_crc_s   = crc_q;
        case (state_q)
            ST_IDLE: begin
                if (i_DV) begin
                    crc_d   = crc_upd_s;
                    count_d = 16'd1;
                    if (i_EOF) begin
                        report_s    = 1'b1;
                        len_err_s   = 1'b1;
                        rpt_count_s = 16'd1;
                        rpt_crc_s   = crc_upd_s;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (i_Abort) begin
                    state_d = ST_IDLE;
                    crc_d   = 16'hFFFF;
                    count_d = 16'd0;
                end else if (i_DV) begin
                    crc_d   = crc_upd_s;
                    count_d = count_sat_s;
                    if (i_EOF) begin
                        report_s    = 1'b1;
                        len_err_s   = too_long_s || (count_inc_s < 17'd3);
                        rpt_count_s = count_sat_s;
                        rpt_crc_s   = crc_upd_s;
                        state_d     = ST_IDLE;
                    end else if (too_long_s) begin
                        state_d = ST_DISCARD;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DISCARD: begin
                // Overlong frame: keep counting, CRC stays frozen.
                if (i_Abort) begin
                    state_d = ST_IDLE;
                    crc_d   = 16'hFFFF;
                    count_d = 16'd0;
                end else if (i_DV) begin
                    count_d = count_sat_s;
                    if (i_EOF) begin
                        report_s    = 1'b1;
                        len_err_s   = 1'b1;
                        rpt_count_s = count_sat_s;
                        rpt_crc_s   = crc_q;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                crc_d   = 16'hFFFF;
                count_d = 16'd0;
            end
        endcase
    end

    // FSM state, running CRC and byte counter.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            crc_q   <= 16'hFFFF;
            count_q <= 16'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            count_q <= count_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Registered frame report; held values only change on a new report.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            done_q       <= 1'b0;
            crc_ok_q     <= 1'b0;
            len_err_q    <= 1'b0;
            byte_count_q <= 16'd0;
            residue_q    <= 16'hFFFF;
        end else begin
            done_q <= report_s;
            if (report_s) begin
                crc_ok_q     <= crc_ok_s;
                len_err_q    <= len_err_s;
                byte_count_q <= rpt_count_s;
                residue_q    <= rpt_crc_s;
            end
        end
    end

    assign o_Busy       = busy_q;
    assign o_Done       = done_q;
    assign o_CRC_OK     = crc_ok_q;
    assign o_Len_Err    = len_err_q;
    assign o_Byte_Count = byte_count_q;
    assign o_Residue    = residue_q;

`ifdef CRC_CHECKER_STATS_EN
    logic [15:0] good_q, bad_q;

    // Saturating result counters, updated alongside the report registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            good_q <= 16'd0;
            bad_q  <= 16'd0;
        end else if (report_s) begin
            if (crc_ok_s) begin
                if (good_q != 16'hFFFF) good_q <= good_q + 16'd1;
            end else begin
                if (bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
            end
        end
    end

    assign o_Good_Count = good_q;
    assign o_Bad_Count  = bad_q;
`endif

endmodule

// File: tb/tb_crc_16_ccitt_checker.sv
// Directed bench for crc_16_ccitt_checker with an expected-result queue per DUT instance.
module tb_crc_16_ccitt_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0, dv8 = 1'b0, eof = 1'b0, abort = 1'b0;
    logic [7:0]  data = 8'h00;

    logic        busy, done, ok, lerr;
    logic [15:0] cnt, res;
    logic        busy8, done8, ok8, lerr8;
    logic [15:0] cnt8, res8;
`ifdef CRC_CHECKER_STATS_EN
    logic [15:0] good_c, bad_c, good_c8, bad_c8;
`endif

    crc_16_ccitt_checker dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_DV(dv), .i_Data(data), .i_EOF(eof), .i_Abort(abort),
        .o_Busy(busy), .o_Done(done), .o_CRC_OK(ok), .o_Len_Err(lerr),
        .o_Byte_Count(cnt), .o_Residue(res)
`ifdef CRC_CHECKER_STATS_EN
        , .o_Good_Count(good_c), .o_Bad_Count(bad_c)
`endif
    );

    crc_16_ccitt_checker #(.MAX_BYTES(8)) dut8 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_DV(dv8), .i_Data(data), .i_EOF(eof), .i_Abort(abort),
        .o_Busy(busy8), .o_Done(done8), .o_CRC_OK(ok8), .o_Len_Err(lerr8),
        .o_Byte_Count(cnt8), .o_Residue(res8)
`ifdef CRC_CHECKER_STATS_EN
        , .o_Good_Count(good_c8), .o_Bad_Count(bad_c8)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cnt;
        logic [15:0] res;
        logic        len_err;
        logic        ok;
        bit          chk_res;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb8[$];
    exp_t        e_m, e_m8;
    int          tests = 0;
    int          fails = 0;
    int          good_exp = 0;
    int          bad_exp = 0;
    logic [15:0] last_cnt = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Bench-side CRC reference: shift in one data bit at a time.
    function automatic logic [15:0] ref_crc(input logic [7:0] f[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (f[k]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ f[k][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 1'b0);
            end else begin
                e_m = sb.pop_front();
                chk("byte_count", cnt, e_m.cnt);
                if (e_m.chk_res) chk("residue", res, e_m.res);
                chk("len_err", lerr, e_m.len_err);
                chk("crc_ok", ok, e_m.ok);
                last_cnt = e_m.cnt;
                if (e_m.ok) good_exp++;
                else bad_exp++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (sb8.size() == 0) begin
                chk("unexpected_done8", done8, 1'b0);
            end else begin
                e_m8 = sb8.pop_front();
                chk("byte_count8", cnt8, e_m8.cnt);
                chk("len_err8", lerr8, e_m8.len_err);
                chk("crc_ok8", ok8, e_m8.ok);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dv = 1'b0; dv8 = 1'b0; eof = 1'b0; abort = 1'b0;
        end
    endtask

    // Drives one frame; pushes the expected report when the EOF byte is driven.
    task automatic send_frame(input logic [7:0] f[$], input int gap_at, input int gap_len,
                              input bit to8, input int n_bytes);
        exp_t        e;
        logic [7:0]  sent[$];
        int          maxb;
        maxb = to8 ? 8 : 1024;
        for (int i = 0; i < n_bytes; i++) begin
            @(negedge clk);
            if (i == 1 && !to8) chk("busy_in_frame", busy, 1'b1);
            abort = 1'b0;
            dv    = !to8;
            dv8   = to8;
            data  = f[i];
            eof   = (i == f.size() - 1);
            sent.push_back(f[i]);
            if (eof) begin
                e.cnt     = 16'(f.size());
                e.res     = ref_crc(sent);
                e.len_err = (f.size() < 3) || (f.size() > maxb);
                e.ok      = (e.res == 16'h0000) && !e.len_err;
                e.chk_res = !to8;
                if (to8) sb8.push_back(e);
                else sb.push_back(e);
            end
            if (i == gap_at) begin
                repeat (gap_len) begin
                    @(negedge clk);
                    dv = 1'b0; dv8 = 1'b0;
                    eof = 1'b1;
                end
            end
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_busy"}, busy, 1'b0);
        chk({pfx, "_done"}, done, 1'b0);
        chk({pfx, "_ok"}, ok, 1'b0);
        chk({pfx, "_lerr"}, lerr, 1'b0);
        chk({pfx, "_cnt"}, cnt, 16'h0000);
        chk({pfx, "_res"}, res, 16'hFFFF);
    endtask

    logic [7:0] good_f[$];
    logic [7:0] bad_f[$];
    logic [7:0] short_f[$];
    logic [7:0] one_f[$];

    initial begin
        good_f  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
        bad_f   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h36, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
        short_f = '{8'h1D, 8'h0F};
        one_f   = '{8'h55};

        repeat (2) @(negedge clk);
        chk_reset_vals("rst_init");
        rst_n = 1'b1;
        idle(2);

        // Golden frame, then same frame with one byte corrupted.
        send_frame(good_f, -1, 0, 1'b0, 11);
        idle(3);
        chk("busy_after_frame", busy, 1'b0);
        send_frame(bad_f, -1, 0, 1'b0, 11);
        idle(3);

        // Gap of 10 cycles (EOF asserted without DV) then back-to-back frame.
        send_frame(good_f, 7, 10, 1'b0, 11);
        send_frame(good_f, -1, 0, 1'b0, 11);
        idle(3);

        // Length errors: short frames, and overlong frame on the MAX_BYTES=8 instance.
        send_frame(short_f, -1, 0, 1'b0, 2);
        send_frame(one_f, -1, 0, 1'b0, 1);
        idle(3);
        send_frame(good_f, -1, 0, 1'b1, 11);
        idle(3);

        // Abort after 5 bytes, then a valid frame.
        send_frame(good_f, -1, 0, 1'b0, 5);
        @(negedge clk);
        dv = 1'b0; eof = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("busy_after_abort", busy, 1'b0);
        chk("held_cnt_after_abort", cnt, last_cnt);
        send_frame(good_f, -1, 0, 1'b0, 11);
        idle(3);
        chk("cnt_after_abort_frame", cnt, 16'd11);

        // Asynchronous reset mid-frame.
        send_frame(good_f, -1, 0, 1'b0, 4);
        @(negedge clk);
        dv = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_mid");
        good_exp = 0;
        bad_exp  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        chk_reset_vals("rst_after");

        send_frame(good_f, -1, 0, 1'b0, 11);
        send_frame(bad_f, -1, 0, 1'b0, 11);
        idle(5);
`ifdef CRC_CHECKER_STATS_EN
        chk("good_count", good_c, 32'(good_exp));
        chk("bad_count", bad_c, 32'(bad_exp));
`endif
        chk("sb_drained", sb.size(), 0);
        chk("sb8_drained", sb8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
